div_share_ctrl: RTL
===================

Name: div_share_ctrl

Overview:
- Sequencing controller that shares one iterative divider (start/done handshake, N-bit quotient and remainder) between two requesters, e.g. the execute stage and the address/CSR path.
- Arbitrates round-robin and captures operands.
- Handles divide-by-zero locally without starting the divider.
- Runs a watchdog on the divider; returns the result to the owning requester as a one-cycle response pulse.

Parameters:
N, 16, operand/result width
TIMEOUT, 64, max cycles in WAIT before abort with error (>=2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  2  per-requester request valid (bit0 = requester 0)
req_ready  output  2  one-hot grant; handshake completes when req_valid[i] & req_ready[i]
req_dividend0  input  N  requester 0 dividend
req_divisor0  input  N  requester 0 divisor
req_dividend1  input  N  requester 1 dividend
req_divisor1  input  N  requester 1 divisor
rsp_valid  output  2  one-hot, one-cycle response pulse to owner
rsp_quotient  output  N  quotient, valid with rsp_valid
rsp_remainder  output  N  remainder, valid with rsp_valid
rsp_error  output  1  divider timeout flag, valid with rsp_valid
div_start  output  1  one-cycle start pulse to divider
div_dividend  output  N  captured dividend, stable from ISSUE until RESP
div_divisor  output  N  captured divisor, stable from ISSUE until RESP
div_done  input  1  divider completion, sampled only in WAIT
div_quotient  input  N  divider quotient, sampled with div_done
div_remainder  input  N  divider remainder, sampled with div_done

Behaviour:
- Reset (reset=0, async):
  - State=IDLE; all outputs 0; operand/result registers 0; timer 0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
  - Asserting reset mid-operation abandons the transaction silently; no rsp_valid is produced.
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered except req_ready.
- IDLE:
  - req_ready is combinational. Single valid requester: it is granted. Both valid: grant the one not equal to last.
  - On handshake, capture that requester's operands and owner.
  - divisor==0: load quotient={N{1'b1}}, remainder=dividend, error=0, go RESP (divider never started).
  - Otherwise go ISSUE.
  - No valid: stay.
- ISSUE:
  - div_start=1 for exactly this cycle; timer cleared; go WAIT.
  - req_ready=0 in every state except IDLE.
- WAIT:
  - Timer increments each cycle.
  - div_done=1: latch div_quotient/div_remainder, error=0, go RESP.
  - Timer reaches TIMEOUT-1 with div_done=0: quotient=0, remainder=0, error=1, go RESP.
  - div_done in the same cycle as the timeout: done wins (error=0).
- RESP:
  - rsp_valid[owner]=1 with results for one cycle; last=owner; go IDLE.
  - Results hold their values after the pulse until overwritten; rsp_valid returns to 0.
- div_done outside WAIT is ignored. Requesters must accept the response pulse; there is no response backpressure.
- Latency:
  - Handshake at cycle A gives div_start at A+1.
  - div_done sampled at cycle D gives rsp_valid at D+1.
  - Divide-by-zero gives rsp_valid at A+1.
  - Next grant at the earliest in the cycle after RESP.
- Arithmetic: unsigned. Operands pass to the divider unmodified; no width extension or truncation.
- A request held without handshake may change its operands; only values at the handshake cycle are used.

Test Plan:
- Req0 100/7, divider model done after 5 cycles:
  - req_ready=01 at accept, div_start one cycle later.
  - rsp_valid=01, q=14, r=2, error=0 exactly one cycle after div_done.
- Both requesters valid every cycle (req0 50/5, req1 9/4):
  - Grants alternate 01,10,01,10.
  - Responses q=10 r=0 and q=2 r=1 routed to the correct rsp_valid bit.
- Req1 1234/0:
  - div_start never asserts.
  - rsp_valid=10 one cycle after accept, q=16'hFFFF, r=1234, error=0.
- Divider model never raises done, TIMEOUT=64:
  - rsp_valid with error=1, q=0, r=0 after 64 WAIT cycles; state returns to IDLE.
  - A following request of 8/2 completes normally: q=4, r=0.
- div_done asserted in the exact timeout cycle with q=3 r=1 → error=0, q=3, r=1.
- Reset low during WAIT, then div_done pulses after release:
  - All outputs 0 and no rsp_valid.
  - Next simultaneous request is granted to requester 0.

Source files
------------

// File: rtl/div_share_ctrl.sv
// Shares one iterative divider between two requesters with round-robin grant.
// Latency: handshake->div_start 1 cycle, div_done->rsp 1 cycle, divide-by-zero->rsp 1 cycle.
// Backpressure: req_ready only in IDLE; responses are one-cycle pulses with no backpressure.
module div_share_ctrl #(
  parameter int N       = 16,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] req_dividend0,
  input  logic [N-1:0] req_divisor0,
  input  logic [N-1:0] req_dividend1,
  input  logic [N-1:0] req_divisor1,
  output logic [1:0]   rsp_valid,
  output logic [N-1:0] rsp_quotient,
  output logic [N-1:0] rsp_remainder,
  output logic         rsp_error,
  output logic         div_start,
  output logic [N-1:0] div_dividend,
  output logic [N-1:0] div_divisor,
  input  logic         div_done,
  input  logic [N-1:0] div_quotient,
  input  logic [N-1:0] div_remainder
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic [N-1:0]  dividend_q, dividend_d;
  logic [N-1:0]  divisor_q, divisor_d;
  logic [N-1:0]  quotient_q, quotient_d;
  logic [N-1:0]  remainder_q, remainder_d;
  logic          error_q, error_d;
  logic [1:0]    rsp_valid_q, rsp_valid_d;
  logic          div_start_q, div_start_d;
  logic [TW-1:0] timer_q, timer_d;

  logic          hs;
  logic [N-1:0]  sel_dividend;
  logic [N-1:0]  sel_divisor;

  assign hs           = |(req_valid & req_ready);
  assign sel_dividend = req_ready[1] ? req_dividend1 : req_dividend0;
  assign sel_divisor  = req_ready[1] ? req_divisor1  : req_divisor0;

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: zero divisor bypasses the divider; done beats the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (hs) state_d = (sel_divisor == '0) ? RESP : ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (div_done || timer_q == TMAX) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: combinational grant plus next values of all registered outputs.
  always_comb begin
    req_ready   = 2'b00;
    last_d      = last_q;
    owner_d     = owner_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    error_d     = error_q;
    rsp_valid_d = 2'b00;
    div_start_d = 1'b0;
    timer_d     = timer_q;
    case (state_q)
      IDLE: begin
        // On a tie the requester that was not served last wins.
        case (req_valid)
          2'b01:   req_ready = 2'b01;
          2'b10:   req_ready = 2'b10;
          2'b11:   req_ready = last_q ? 2'b01 : 2'b10;
          default: req_ready = 2'b00;
        endcase
        if (hs) begin
          owner_d    = req_ready[1];
          dividend_d = sel_dividend;
          divisor_d  = sel_divisor;
          if (sel_divisor == '0) begin
            quotient_d  = '1;
            remainder_d = sel_dividend;
            error_d     = 1'b0;
            rsp_valid_d = req_ready;
          end else begin
            div_start_d = 1'b1;
          end
        end
      end
      ISSUE: timer_d = '0;
      WAIT: begin
        timer_d = timer_q + 1'b1;
        if (div_done) begin
          quotient_d  = div_quotient;
          remainder_d = div_remainder;
          error_d     = 1'b0;
          rsp_valid_d = {owner_q, ~owner_q};
        end else if (timer_q == TMAX) begin
          quotient_d  = '0;
          remainder_d = '0;
          error_d     = 1'b1;
          rsp_valid_d = {owner_q, ~owner_q};
        end
      end
      RESP: last_d = owner_q;
      default: ;
    endcase
  end

  // Datapath and registered output flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      error_q     <= 1'b0;
      rsp_valid_q <= 2'b00;
      div_start_q <= 1'b0;
      timer_q     <= '0;
    end else begin
      last_q      <= last_d;
      owner_q     <= owner_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      error_q     <= error_d;
      rsp_valid_q <= rsp_valid_d;
      div_start_q <= div_start_d;
      timer_q     <= timer_d;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_quotient  = quotient_q;
  assign rsp_remainder = remainder_q;
  assign rsp_error     = error_q;
  assign div_start     = div_start_q;
  assign div_dividend  = dividend_q;
  assign div_divisor   = divisor_q;

endmodule
